mem_wait_ctrl: RTL and testbench
================================

# mem_wait_ctrl

Bus wait-state and access-fault controller for the GBA CPU memory system. It sits beside the simulation memory regions on the shared CPU bus (ADDR/SIZE/WRITE/WDATA) and drives PAUSE and ABORT. It replaces fixed per-region pause stubs with GBA-accurate timing:
- region decode;
- WAITCNT-programmable GamePak/SRAM wait states;
- sequential-access detection;
- 16-bit bus doubling for word accesses;
- illegal-access abort.

## Interface
- No parameters. WAITCNT reset value is fixed at 16'h0000.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- addr  in  32  CPU address of the access being presented.
- size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- write  in  1  access is a write.
- wdata  in  32  write data, valid the cycle after the address is accepted.
- pause  out  1  stall to CPU and memories. Moore output from state, with no comb path from addr.
- abort  out  1  access fault, registered, one-cycle pulse.
- seq  out  1  registered: the last accepted access was sequential (debug/bus log).
- waitcnt  out  16  current WAITCNT register value.

## Operation
- **Acceptance.** An access is accepted at any rising edge where pause=0 and rst_n=1. While pause=1, addr, size and write are ignored.
- **States:**
  - IDLE: pause=0.
  - WAIT: pause=1, down-counter cnt[4:0].
  - On acceptance with W>0: go to WAIT with cnt=W.
  - In WAIT: cnt decrements each edge; cnt==1 at an edge returns to IDLE.
- **Region decode on addr[31:24] and waits (W):**
  - 00: BIOS, valid only below 0x0000_4000. W=0.
  - 02: EWRAM. W=2 byte/half, 5 word.
  - 03–07: IWRAM, IO, palette, VRAM, OAM. W=0.
  - 08/09: WS0.
  - 0A/0B: WS1.
  - 0C/0D: WS2.
  - 0E/0F: SRAM. W=sram for every size.
  - All other addresses, and 0x0000_4000–0x01FF_FFFF: unmapped.
- **WAITCNT field decode** (N codes 0..3 map to 4,3,2,8):
  - sram = [1:0] via N code.
  - WS0: n=[3:2] via N code; s=[4]?1:2.
  - WS1: n=[6:5] via N code; s=[7]?1:4.
  - WS2: n=[9:8] via N code; s=[10]?1:8.
- **ROM timing:**
  - Byte/half: W = seq ? s : n.
  - Word: W = (seq ? s : n) + s + 1.
- **Sequential (seq).** All of the following must hold:
  - previous accepted access was in the same WS region;
  - addr == prev_addr + {1,2,4}[prev_size];
  - addr[16:0] != 0 (128 KB prefetch boundary forces non-sequential).
  - seq is never set for non-ROM regions.
  - prev_addr and prev_size update on every accepted access, including aborted ones.
- **Abort (W forced to 0, no pause):**
  - write to BIOS or WS0–WS2;
  - any access to an unmapped address;
  - size==11.
  - abort is high for exactly the cycle following the acceptance edge.
- **WAITCNT write:**
  - Trigger: accepted, non-aborted write, size half or word, with addr[31:2]==0x0400_0204>>2 and addr[1]==0.
  - Effect: waitcnt <= wdata[15:0] at the next edge with pause=0.
  - A half write to 0x0400_0206 and byte writes to 0x0400_0204/0x0400_0205 leave waitcnt unchanged.
  - The new value applies to accesses accepted from the edge after the update.

## Timing
- Reset values: pause=0, abort=0, seq=0, waitcnt=16'h0000, state IDLE, prev_addr=0, prev_size=0. Reset takes effect immediately and asynchronously, including mid-WAIT.
- Access presented in cycle c0 and accepted at the end of c0:
  - pause=1 for cycles c1..cW exactly;
  - pause=0 in cycle c(W+1);
  - the next access is accepted at the end of c(W+1).
- W=0: back-to-back acceptance every cycle.
- Maximum W = 8+8+1 = 17, so cnt is 5 bits.
- seq and abort update at the acceptance edge.
- The WAITCNT data phase falls in c1. IO region W=0, so c1 always has pause=0.
- Simultaneous WAITCNT update and acceptance at one edge: the access accepted at that edge uses the old value.

## Test plan
- **Reset.** Hold rst_n=0, then release → pause=0, abort=0, seq=0, waitcnt=0000. Read 0x0300_0000 repeatedly → pause never asserts.
- **EWRAM.**
  - Half read 0x0200_0010 → pause high exactly 2 cycles.
  - Word read 0x0200_0014 → pause high 5 cycles.
- **WS0 at reset WAITCNT.**
  - Half read 0x0800_0000 → 4 waits, seq=0.
  - Half read 0x0800_0002 → 2 waits, seq=1.
  - Half read 0x0800_0008 → 4 waits.
  - Word read 0x0800_0100 → 7 waits.
  - Half reads 0x0801_FFFE then 0x0802_0000 → second access 4 waits, seq=0.
- **WAITCNT programming.**
  - Word write 0x0400_0204 with wdata 0x0000_0014 → waitcnt=0014.
  - Then half reads 0x0800_0000 → 3 waits; 0x0800_0002 → 1 wait.
  - Half write 0x0400_0206 → waitcnt unchanged.
- **Aborts.** Each of the following → abort=1 for one cycle after acceptance, pause stays 0, waitcnt unchanged:
  - byte write 0x0800_0000;
  - word write 0x0000_1000;
  - read 0x1000_0000;
  - read 0x0100_0000;
  - size=11 at 0x0300_0000.
- **Reset mid-operation.** During a 4-wait ROM access with waitcnt=0014, pulse rst_n low in the second wait cycle → pause falls without waiting for clk, waitcnt=0000. The next access to 0x0800_0002 after release is non-sequential, 4 waits.

Source files
------------

// File: rtl/mem_wait_ctrl.sv
// GBA bus wait-state / access-fault controller: decodes the presented access,
// stalls the CPU for the region's wait count and flags illegal accesses.
module mem_wait_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        pause,
  output logic        abort,
  output logic        seq,
  output logic [15:0] waitcnt
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  typedef enum logic [2:0] {
    RG_BIOS,
    RG_EWRAM,
    RG_FAST,
    RG_WS0,
    RG_WS1,
    RG_WS2,
    RG_SRAM,
    RG_UNMAP
  } region_e;

  function automatic region_e decode(input logic [31:0] a);
    region_e r;
    case (a[31:24])
      8'h00:                             r = (a[23:14] == '0) ? RG_BIOS : RG_UNMAP;
      8'h02:                             r = RG_EWRAM;
      8'h03, 8'h04, 8'h05, 8'h06, 8'h07: r = RG_FAST;
      8'h08, 8'h09:                      r = RG_WS0;
      8'h0A, 8'h0B:                      r = RG_WS1;
      8'h0C, 8'h0D:                      r = RG_WS2;
      8'h0E, 8'h0F:                      r = RG_SRAM;
      default:                           r = RG_UNMAP;
    endcase
    return r;
  endfunction

  function automatic logic [4:0] ncode(input logic [1:0] c);
    logic [4:0] w;
    case (c)
      2'd0:    w = 5'd4;
      2'd1:    w = 5'd3;
      2'd2:    w = 5'd2;
      default: w = 5'd8;
    endcase
    return w;
  endfunction

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic        seq_q, seq_d;
  logic [31:0] prev_addr_q, prev_addr_d;
  logic [1:0]  prev_size_q, prev_size_d;
  logic [15:0] waitcnt_q, waitcnt_d;
  logic        wc_pend_q, wc_pend_d;

  region_e     cur_rg, prev_rg;
  logic        is_rom;
  logic        abort_hit;
  logic        seq_hit;
  logic        wc_hit;
  logic [31:0] step;
  logic [4:0]  n_w, s_w, base_w, acc_w;

  // Only the low half of the data bus carries the WAITCNT register.
  logic        unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  always_comb begin
    cur_rg  = decode(addr);
    prev_rg = decode(prev_addr_q);
    is_rom  = (cur_rg == RG_WS0) || (cur_rg == RG_WS1) || (cur_rg == RG_WS2);

    case (prev_size_q)
      2'b00:   step = 32'd1;
      2'b01:   step = 32'd2;
      2'b10:   step = 32'd4;
      default: step = 32'd0;
    endcase

    abort_hit = (size == 2'b11) || (cur_rg == RG_UNMAP) ||
                (write && ((cur_rg == RG_BIOS) || is_rom));

    // 128 KB prefetch boundary always restarts a non-sequential burst.
    seq_hit = is_rom && (cur_rg == prev_rg) && (prev_size_q != 2'b11) &&
              (addr == prev_addr_q + step) && (addr[16:0] != '0) && !abort_hit;

    case (cur_rg)
      RG_WS0: begin
        n_w = ncode(waitcnt_q[3:2]);
        s_w = waitcnt_q[4] ? 5'd1 : 5'd2;
      end
      RG_WS1: begin
        n_w = ncode(waitcnt_q[6:5]);
        s_w = waitcnt_q[7] ? 5'd1 : 5'd4;
      end
      RG_WS2: begin
        n_w = ncode(waitcnt_q[9:8]);
        s_w = waitcnt_q[10] ? 5'd1 : 5'd8;
      end
      default: begin
        n_w = ncode(waitcnt_q[1:0]);
        s_w = 5'd0;
      end
    endcase

    base_w = seq_hit ? s_w : n_w;

    // Word access on the 16-bit GamePak bus costs a second, always-sequential beat.
    case (cur_rg)
      RG_EWRAM:               acc_w = (size == 2'b10) ? 5'd5 : 5'd2;
      RG_WS0, RG_WS1, RG_WS2: acc_w = (size == 2'b10) ? (base_w + s_w + 5'd1) : base_w;
      RG_SRAM:                acc_w = n_w;
      default:                acc_w = 5'd0;
    endcase
    if (abort_hit) acc_w = 5'd0;

    wc_hit = write && !abort_hit && ((size == 2'b01) || (size == 2'b10)) &&
             (addr[31:2] == 30'h0100_0081) && !addr[1];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = 1'b0;
    seq_d       = seq_q;
    prev_addr_d = prev_addr_q;
    prev_size_d = prev_size_q;
    waitcnt_d   = waitcnt_q;
    wc_pend_d   = wc_pend_q;

    case (state_q)
      ST_IDLE: begin
        // Data phase of a pending WAITCNT write; the access accepted here still sees the old value.
        if (wc_pend_q) waitcnt_d = wdata[15:0];
        abort_d     = abort_hit;
        seq_d       = seq_hit;
        prev_addr_d = addr;
        prev_size_d = size;
        wc_pend_d   = wc_hit;
        if (acc_w != '0) begin
          state_d = ST_WAIT;
          cnt_d   = acc_w;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      seq_q       <= 1'b0;
      prev_addr_q <= '0;
      prev_size_q <= '0;
      waitcnt_q   <= '0;
      wc_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      seq_q       <= seq_d;
      prev_addr_q <= prev_addr_d;
      prev_size_q <= prev_size_d;
      waitcnt_q   <= waitcnt_d;
      wc_pend_q   <= wc_pend_d;
    end
  end

  assign pause   = (state_q == ST_WAIT);
  assign abort   = abort_q;
  assign seq     = seq_q;
  assign waitcnt = waitcnt_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Bench for mem_wait_ctrl: directed GBA timing cases plus random accesses
// scored against a transaction-level model of the wait/abort/seq rules.
module tb_mem_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'h0300_0000;
  logic [1:0]  size = 2'b01;
  logic        write = 1'b0;
  logic [31:0] wdata = '0;
  logic        pause, abort, seq;
  logic [15:0] waitcnt;

  int unsigned total = 0;
  int unsigned bad = 0;

  // transaction-level model state
  logic [31:0] m_prev_addr;
  logic [1:0]  m_prev_size;
  logic [15:0] m_wc;
  logic        m_pend;
  logic [15:0] m_pend_val;

  mem_wait_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .size    (size),
    .write   (write),
    .wdata   (wdata),
    .pause   (pause),
    .abort   (abort),
    .seq     (seq),
    .waitcnt (waitcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ws_index(input logic [31:0] a);
    if (a[31:24] >= 8'h08 && a[31:24] <= 8'h0D) return (int'(a[31:24]) - 8) / 2;
    return -1;
  endfunction

  task automatic m_expect(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                          output int unsigned w, output logic ab, output logic sq,
                          output logic wc);
    int unsigned nt [4] = '{4, 3, 2, 8};
    logic [7:0]  pg = a[31:24];
    int          ws = ws_index(a);
    int          pws = ws_index(m_prev_addr);
    logic        unmapped;
    int unsigned n, s, b;
    unmapped = (pg == 8'h00 && a >= 32'h0000_4000) || pg == 8'h01 || pg > 8'h0F;
    ab = (sz == 2'b11) || unmapped || (wr && (pg == 8'h00 || ws >= 0));
    sq = !ab && ws >= 0 && ws == pws && a == m_prev_addr + (32'd1 << m_prev_size) &&
         a[16:0] != 17'd0;
    if (ab) w = 0;
    else if (pg == 8'h02) w = (sz == 2'b10) ? 5 : 2;
    else if (ws >= 0) begin
      n = nt[int'((m_wc >> (2 + 3 * ws)) & 16'h3)];
      s = m_wc[4 + 3 * ws] ? 1 : (2 << ws);
      b = sq ? s : n;
      w = (sz == 2'b10) ? b + s + 1 : b;
    end
    else if (pg == 8'h0E || pg == 8'h0F) w = nt[m_wc[1:0]];
    else w = 0;
    wc = wr && !ab && (sz == 2'b01 || sz == 2'b10) && ((a & ~32'h1) == 32'h0400_0204);
  endtask

  task automatic m_reset();
    m_prev_addr = '0;
    m_prev_size = '0;
    m_wc        = '0;
    m_pend      = 1'b0;
    m_pend_val  = '0;
  endtask

  // Presents one access in the current (unpaused) cycle and follows it to completion.
  task automatic do_access(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                           input logic [31:0] wd, input string tag);
    int unsigned ew, n;
    logic eab, esq, ewc;
    m_expect(a, sz, wr, ew, eab, esq, ewc);
    addr  = a;
    size  = sz;
    write = wr;
    @(posedge clk);
    #1;
    wdata = wd;
    if (m_pend) begin
      m_wc   = m_pend_val;
      m_pend = 1'b0;
    end
    m_prev_addr = a;
    m_prev_size = sz;
    if (ewc) begin
      m_pend     = 1'b1;
      m_pend_val = wd[15:0];
    end
    chk($sformatf("%s@%h abort", tag, a), 32'(abort), 32'(eab));
    chk($sformatf("%s@%h seq", tag, a), 32'(seq), 32'(esq));
    chk($sformatf("%s@%h waitcnt", tag, a), 32'(waitcnt), 32'(m_wc));
    n = 0;
    while (pause === 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk($sformatf("%s@%h waits", tag, a), n, ew);
  endtask

  logic [7:0] pages [18] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                             8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h01, 8'h10, 8'hFF};

  initial begin
    m_reset();
    #12;
    chk("rst pause", 32'(pause), 32'd0);
    chk("rst abort", 32'(abort), 32'd0);
    chk("rst seq", 32'(seq), 32'd0);
    chk("rst waitcnt", 32'(waitcnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");

    do_access(32'h0200_0010, 2'b01, 1'b0, '0, "ewram_h");
    do_access(32'h0200_0014, 2'b10, 1'b0, '0, "ewram_w");

    do_access(32'h0800_0000, 2'b01, 1'b0, '0, "ws0");
    do_access(32'h0800_0002, 2'b01, 1'b0, '0, "ws0");
    do_access(32'h0800_0008, 2'b01, 1'b0, '0, "ws0");
    do_access(32'h0800_0100, 2'b10, 1'b0, '0, "ws0_w");
    do_access(32'h0801_FFFE, 2'b01, 1'b0, '0, "ws0_bnd");
    do_access(32'h0802_0000, 2'b01, 1'b0, '0, "ws0_bnd");

    do_access(32'h0400_0204, 2'b10, 1'b1, 32'h0000_0014, "wc_wr");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    chk("waitcnt programmed", 32'(waitcnt), 32'h0014);
    do_access(32'h0800_0000, 2'b01, 1'b0, '0, "ws0_new");
    do_access(32'h0800_0002, 2'b01, 1'b0, '0, "ws0_new");
    do_access(32'h0400_0206, 2'b01, 1'b1, 32'h0000_FFFF, "wc_hi");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    do_access(32'h0400_0204, 2'b00, 1'b1, 32'h0000_FFFF, "wc_byte");
    do_access(32'h0400_0205, 2'b00, 1'b1, 32'h0000_FFFF, "wc_byte");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    chk("waitcnt kept", 32'(waitcnt), 32'h0014);

    do_access(32'h0800_0000, 2'b00, 1'b1, '0, "ab_romwr");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    do_access(32'h0000_1000, 2'b10, 1'b1, '0, "ab_bioswr");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    do_access(32'h1000_0000, 2'b10, 1'b0, '0, "ab_unmap");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    do_access(32'h0100_0000, 2'b01, 1'b0, '0, "ab_hole");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    do_access(32'h0300_0000, 2'b11, 1'b0, '0, "ab_size");
    do_access(32'h0300_0000, 2'b01, 1'b0, '0, "iwram");
    chk("waitcnt after aborts", 32'(waitcnt), 32'h0014);

    // WS1 half read is 4 waits with waitcnt=0014; reset lands in its second wait cycle.
    addr  = 32'h0A00_0000;
    size  = 2'b01;
    write = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst pause c1", 32'(pause), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst pause", 32'(pause), 32'd0);
    chk("midrst waitcnt", 32'(waitcnt), 32'h0);
    chk("midrst seq", 32'(seq), 32'd0);
    #1;
    rst_n = 1'b1;
    m_reset();
    do_access(32'h0800_0002, 2'b01, 1'b0, '0, "post_rst");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic        wr;
      logic [7:0]  pg;
      int unsigned r;
      r  = $urandom_range(0, 99);
      sz = 2'($urandom_range(0, 2));
      wr = ($urandom_range(0, 4) == 0);
      if (r < 35 && ws_index(m_prev_addr) >= 0) begin
        a = m_prev_addr + (32'd1 << m_prev_size);
      end else if (r < 45) begin
        a  = 32'h0400_0204 | 32'($urandom_range(0, 3));
        wr = 1'b1;
      end else if (r < 50) begin
        a = {8'h08 + 8'($urandom_range(0, 5)), 7'd0, 17'h1FFFE};
      end else begin
        pg = pages[$urandom_range(0, 17)];
        a  = {pg, 24'($urandom)};
        if (pg == 8'h00 && $urandom_range(0, 1) == 1) a = {18'd0, 14'($urandom)};
        if (r >= 96 && !(pg >= 8'h08 && pg <= 8'h0D)) sz = 2'b11;
      end
      do_access(a, sz, wr, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
